// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: hold request / grant FSM over four channels with fixed
// or rotating priority. Define ROTATING_PRIORITY_EN to build the rotation logic.
module dma_channel_arbiter #(
  parameter int HLDA_TIMEOUT = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic       priorityType,
  input  logic       HLDA,
  input  logic       serviceDone,
  input  logic       EOP_N,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] activeChannel,
  output logic [7:0] priorityOrder,
  output logic       timeoutErr
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOLD_REQ = 2'd1;
  localparam logic [1:0] GRANT    = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [7:0] ORDER_RST = 8'b11_10_01_00;
  localparam int         CW        = (HLDA_TIMEOUT < 2) ? 1 : $clog2(HLDA_TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM   = CW'(HLDA_TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] tcnt;
  logic [3:0]    req;
  logic [1:0]    winner;
  logic          rotate;

  assign req    = DREQ & ~maskReg;
  assign rotate = (state == GRANT) && (serviceDone || !EOP_N);

  // Walk the order from lowest to highest slot so the highest-priority hit wins.
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[priorityOrder[2*k +: 2]]) winner = priorityOrder[2*k +: 2];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= 4'b0000;
      activeChannel <= 2'b00;
      timeoutErr    <= 1'b0;
      tcnt          <= '0;
    end else begin
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state <= HOLD_REQ;
            HRQ   <= 1'b1;
            tcnt  <= '0;
          end
        end
        HOLD_REQ: begin
          if (req == 4'b0000) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state         <= GRANT;
            DACK          <= 4'b0001 << winner;
            activeChannel <= winner;
          end else if (HLDA_TIMEOUT != 0 && tcnt == TLIM) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            timeoutErr <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        GRANT: begin
          // Completion wins over a simultaneous HLDA drop so rotation still applies.
          if (rotate) begin
            state <= RELEASE;
            HRQ   <= 1'b0;
            DACK  <= 4'b0000;
          end else if (!HLDA) begin
            state <= IDLE;
            HRQ   <= 1'b0;
            DACK  <= 4'b0000;
          end
        end
        RELEASE: begin
          if (!HLDA) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          HRQ   <= 1'b0;
          DACK  <= 4'b0000;
        end
      endcase
    end
  end

`ifdef ROTATING_PRIORITY_EN
  // Served channel drops to the bottom; the others keep their cyclic order.
  always_ff @(posedge CLK) begin
    if (RESET || !priorityType)
      priorityOrder <= ORDER_RST;
    else if (rotate)
      priorityOrder <= {activeChannel, activeChannel + 2'd3,
                        activeChannel + 2'd2, activeChannel + 2'd1};
  end
`else
  // priorityType is accepted but has no effect without rotation; the AND folds away.
  assign priorityOrder = ORDER_RST | {8{priorityType & 1'b0}};
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: grants are checked against a queue of
// expected (DACK, channel) pairs pushed when each request is driven.
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       HLDA;
  logic       serviceDone;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic [7:0] priorityOrder;
  logic       timeoutErr;

  typedef struct {
    logic [3:0] dack;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [3:0] prev_dack = 4'b0000;

  localparam logic [7:0] ORD0 = 8'b11_10_01_00;

  dma_channel_arbiter #(.HLDA_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (DREQ),
    .maskReg      (maskReg),
    .priorityType (priorityType),
    .HLDA         (HLDA),
    .serviceDone  (serviceDone),
    .EOP_N        (EOP_N),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .activeChannel(activeChannel),
    .priorityOrder(priorityOrder),
    .timeoutErr   (timeoutErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Request, wait two cycles with HRQ up, raise HLDA, expect the grant.
  task automatic do_grant(input logic [3:0] dreq, input logic [3:0] exp_dack,
                          input logic [1:0] exp_ch);
    exp_t e;
    DREQ = dreq;
    step();
    chk("hrq_rise", HRQ, 1);
    chk("dack_before_hlda", DACK, 0);
    step();
    step();
    HLDA = 1'b1;
    e.dack = exp_dack;
    e.ch   = exp_ch;
    sb.push_back(e);
    step();
    chk("grant_hrq", HRQ, 1);
  endtask

  task automatic do_release();
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    chk("release_hrq", HRQ, 0);
    chk("release_dack", DACK, 0);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    step();
    step();
  endtask

  // Scoreboard side: every DACK rising edge consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      chk("dack_onehot0", $onehot0(DACK), 1);
      if (DACK != 4'b0000) chk("dack_implies_hrq", HRQ, 1);
      if (DACK != 4'b0000 && prev_dack == 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", DACK, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_dack", DACK, e.dack);
          chk("sb_channel", activeChannel, e.ch);
        end
      end
      prev_dack = DACK;
    end
  end

  initial begin
    RESET = 1'b1; DREQ = 4'b0000; maskReg = 4'b0000; priorityType = 1'b0;
    HLDA = 1'b0; serviceDone = 1'b0; EOP_N = 1'b1;
    step();
    step();
    chk("rst_hrq", HRQ, 0);
    chk("rst_dack", DACK, 0);
    chk("rst_ch", activeChannel, 0);
    chk("rst_order", priorityOrder, ORD0);
    chk("rst_terr", timeoutErr, 0);
    RESET = 1'b0;
    step();
    chk("idle_hrq", HRQ, 0);

    // Fixed priority; later DREQ changes must not move the winner.
    do_grant(4'b1110, 4'b0010, 2'd1);
    chk("fixed_dack", DACK, 4'b0010);
    DREQ = 4'b0001;
    step();
    chk("winner_latched", DACK, 4'b0010);
    chk("winner_latched_ch", activeChannel, 1);
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    chk("rel_hrq", HRQ, 0);
    step();
    chk("rel_hold_hlda", HRQ, 0);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    step();
    step();

    // Mask
    maskReg = 4'b0001;
    do_grant(4'b0011, 4'b0010, 2'd1);
    do_release();
    maskReg = 4'b1111;
    DREQ = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("masked_no_hrq", HRQ, 0);
    end
    DREQ = 4'b0000;
    maskReg = 4'b0000;
    step();

`ifdef ROTATING_PRIORITY_EN
    priorityType = 1'b1;
    do_grant(4'b1111, 4'b0001, 2'd0);
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    chk("rot_order_c0", priorityOrder, 8'b00_11_10_01);
    HLDA = 1'b0; DREQ = 4'b0000;
    step();
    step();
    do_grant(4'b1111, 4'b0010, 2'd1);
    do_release();
    chk("rot_order_c1", priorityOrder, 8'b01_00_11_10);
    priorityType = 1'b0;
    step();
    chk("fixed_forces_order", priorityOrder, ORD0);
`else
    priorityType = 1'b1;
    do_grant(4'b1111, 4'b0001, 2'd0);
    do_release();
    chk("no_rot_order", priorityOrder, ORD0);
    priorityType = 1'b0;
`endif

    // HLDA timeout (HLDA_TIMEOUT=4): four HOLD_REQ cycles then abandon.
    DREQ = 4'b0001;
    step();
    chk("to_hrq", HRQ, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_terr", timeoutErr, 0);
      chk("to_wait_hrq", HRQ, 1);
    end
    step();
    chk("to_pulse", timeoutErr, 1);
    chk("to_hrq_drop", HRQ, 0);
    DREQ = 4'b0000;
    step();
    chk("to_pulse_end", timeoutErr, 0);
    chk("to_idle_hrq", HRQ, 0);

    // Abort on HLDA drop in GRANT
    do_grant(4'b0100, 4'b0100, 2'd2);
    chk("abort_pre_dack", DACK, 4'b0100);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    step();
    chk("abort_dack", DACK, 0);
    chk("abort_hrq", HRQ, 0);
    chk("abort_order", priorityOrder, ORD0);
    step();

    // Reset mid-GRANT
    do_grant(4'b0100, 4'b0100, 2'd2);
    RESET = 1'b1;
    step();
    chk("rst2_hrq", HRQ, 0);
    chk("rst2_dack", DACK, 0);
    chk("rst2_ch", activeChannel, 0);
    chk("rst2_order", priorityOrder, ORD0);
    chk("rst2_terr", timeoutErr, 0);
    RESET = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
    step();

    // EOP terminates service
    do_grant(4'b1000, 4'b1000, 2'd3);
    EOP_N = 1'b0;
    step();
    EOP_N = 1'b1;
    chk("eop_hrq", HRQ, 0);
    chk("eop_dack", DACK, 0);
    step();
    chk("eop_rel_hrq", HRQ, 0);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    step();
    DREQ = 4'b0001;
    step();
    chk("eop_idle_rerequest", HRQ, 1);
    DREQ = 4'b0000;
    step();
    chk("hold_req_withdrawn", HRQ, 0);

    // serviceDone with HLDA dropping: RELEASE wins, so an extra idle cycle follows.
    do_grant(4'b0010, 4'b0010, 2'd1);
    serviceDone = 1'b1;
    HLDA = 1'b0;
    step();
    serviceDone = 1'b0;
    chk("simul_dack", DACK, 0);
    step();
    chk("simul_release_idle", HRQ, 0);
    step();
    chk("simul_rerequest", HRQ, 1);
    DREQ = 4'b0000;
    step();
    step();

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
